// File: rtl/mmio_periph_ctrl.sv
// Memory-mapped KEY/SW/LED/HEX controller with synchronised inputs, sticky status and HEX decode.
// Optional millisecond-style timer (TCNT/TLIM/TCTL) compiled in when MMIO_TIMER_EN is defined.
module mmio_periph_ctrl #(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int LEDR_BITS       = 10,
    parameter int LEDG_BITS       = 8,
    parameter int HEX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000,
    parameter logic [DBITS-1:0] ADDR_HEX   = DBITS'(32'hF000_0000),
    parameter logic [DBITS-1:0] ADDR_LEDR  = DBITS'(32'hF000_0004),
    parameter logic [DBITS-1:0] ADDR_LEDG  = DBITS'(32'hF000_0008),
    parameter logic [DBITS-1:0] ADDR_KDATA = DBITS'(32'hF000_0010),
    parameter logic [DBITS-1:0] ADDR_KCTRL = DBITS'(32'hF000_0110),
    parameter logic [DBITS-1:0] ADDR_SDATA = DBITS'(32'hF000_0014),
    parameter logic [DBITS-1:0] ADDR_SCTRL = DBITS'(32'hF000_0114),
    parameter logic [DBITS-1:0] ADDR_TCNT  = DBITS'(32'hF000_0020),
    parameter logic [DBITS-1:0] ADDR_TLIM  = DBITS'(32'hF000_0024),
    parameter logic [DBITS-1:0] ADDR_TCTL  = DBITS'(32'hF000_0120)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        addr,
    input  logic                    rdEn,
    input  logic                    wrEn,
    input  logic [DBITS-1:0]        wdata,
    output logic [DBITS-1:0]        rdata,
    output logic                    hit,
    input  logic [KEY_BITS-1:0]     key,
    input  logic [SW_BITS-1:0]      sw,
    output logic [LEDR_BITS-1:0]    ledr,
    output logic [LEDG_BITS-1:0]    ledg,
    output logic [7*HEX_DIGITS-1:0] hex
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Returns {overrun, ready}; an update concurrent with a data read keeps ready without overrun.
    function automatic logic [1:0] status_next(input logic rdy, input logic ovr, input logic upd,
                                               input logic rd, input logic clr_ovr);
        logic rdy_n;
        logic ovr_n;
        rdy_n = rdy;
        ovr_n = clr_ovr ? 1'b0 : ovr;
        if (upd) begin
            rdy_n = 1'b1;
            if (rdy && !rd) ovr_n = 1'b1;
        end else if (rd) begin
            rdy_n = 1'b0;
        end
        return {ovr_n, rdy_n};
    endfunction

    logic sel_hex, sel_ledr, sel_ledg, sel_kdata, sel_kctrl, sel_sdata, sel_sctrl;
    logic sel_tcnt, sel_tlim, sel_tctl;
    assign sel_hex   = (addr == ADDR_HEX);
    assign sel_ledr  = (addr == ADDR_LEDR);
    assign sel_ledg  = (addr == ADDR_LEDG);
    assign sel_kdata = (addr == ADDR_KDATA);
    assign sel_kctrl = (addr == ADDR_KCTRL);
    assign sel_sdata = (addr == ADDR_SDATA);
    assign sel_sctrl = (addr == ADDR_SCTRL);
    assign sel_tcnt  = (addr == ADDR_TCNT);
    assign sel_tlim  = (addr == ADDR_TLIM);
    assign sel_tctl  = (addr == ADDR_TCTL);

    logic [4*HEX_DIGITS-1:0] hex_q;
    logic [LEDR_BITS-1:0]    ledr_q;
    logic [LEDG_BITS-1:0]    ledg_q;

    // Keys are inverted before synchronising so the all-zero reset state means "nothing pressed".
    logic [KEY_BITS-1:0] key_s1_q, key_s2_q, kdata_q;
    logic                krdy_q, kovr_q;
    logic [1:0]          kstat_d;
    logic                key_upd;

    logic [SW_BITS-1:0]  sw_s1_q, sw_s2_q, sw_prev_q, sdata_q;
    logic [CW-1:0]       deb_cnt_q, deb_cnt_d;
    logic                srdy_q, sovr_q;
    logic [1:0]          sstat_d;
    logic                sw_upd;

    assign key_upd = (key_s2_q != kdata_q);
    assign sw_upd  = (deb_cnt_q == DEB_LAST) && (sw_s2_q == sw_prev_q) && (sw_prev_q != sdata_q);
    assign kstat_d = status_next(krdy_q, kovr_q, key_upd, rdEn && sel_kdata,
                                 wrEn && sel_kctrl && !wdata[2]);
    assign sstat_d = status_next(srdy_q, sovr_q, sw_upd, rdEn && sel_sdata,
                                 wrEn && sel_sctrl && !wdata[2]);

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (sw_s2_q != sw_prev_q) deb_cnt_d = '0;
        else if (deb_cnt_q != DEB_LAST) deb_cnt_d = deb_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q     <= '0;
            ledr_q    <= '0;
            ledg_q    <= '0;
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            kdata_q   <= '0;
            krdy_q    <= 1'b0;
            kovr_q    <= 1'b0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prev_q <= '0;
            sdata_q   <= '0;
            deb_cnt_q <= '0;
            srdy_q    <= 1'b0;
            sovr_q    <= 1'b0;
        end else begin
            if (wrEn && sel_hex)  hex_q  <= wdata[4*HEX_DIGITS-1:0];
            if (wrEn && sel_ledr) ledr_q <= wdata[LEDR_BITS-1:0];
            if (wrEn && sel_ledg) ledg_q <= wdata[LEDG_BITS-1:0];
            key_s1_q  <= ~key;
            key_s2_q  <= key_s1_q;
            if (key_upd) kdata_q <= key_s2_q;
            {kovr_q, krdy_q} <= kstat_d;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            sw_prev_q <= sw_s2_q;
            deb_cnt_q <= deb_cnt_d;
            if (sw_upd) sdata_q <= sw_prev_q;
            {sovr_q, srdy_q} <= sstat_d;
        end
    end

`ifdef MMIO_TIMER_EN
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             trdy_q, tovr_q, t_wrap;
    logic [1:0]       tstat_d;
    logic             tmr_hit;

    always_comb begin
        tcnt_d  = tcnt_q;
        presc_d = presc_q + 1'b1;
        t_wrap  = 1'b0;
        if (presc_q == TICK_LAST) begin
            presc_d = '0;
            if ((tlim_q != '0) && (tcnt_q == tlim_q - 1'b1)) begin
                tcnt_d = '0;
                t_wrap = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
        // A software load overrides a coincident tick, including its wrap.
        if (wrEn && sel_tcnt) begin
            tcnt_d  = wdata;
            presc_d = '0;
            t_wrap  = 1'b0;
        end
    end

    assign tstat_d = status_next(trdy_q, tovr_q, t_wrap, rdEn && sel_tcnt,
                                 wrEn && sel_tctl && !wdata[2]);
    assign tmr_hit = sel_tcnt | sel_tlim | sel_tctl;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            tlim_q  <= '0;
            presc_q <= '0;
            trdy_q  <= 1'b0;
            tovr_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            presc_q <= presc_d;
            if (wrEn && sel_tlim) tlim_q <= wdata;
            {tovr_q, trdy_q} <= tstat_d;
        end
    end
`else
    logic tmr_hit;
    logic unused_tmr;
    assign tmr_hit    = 1'b0;
    assign unused_tmr = ^{sel_tcnt, sel_tlim, sel_tctl, 32'(TICK_CYCLES)};
`endif

    always_comb begin
        rdata = '0;
        hit   = sel_hex | sel_ledr | sel_ledg | sel_kdata | sel_kctrl |
                sel_sdata | sel_sctrl | tmr_hit;
        if (sel_hex)   rdata[4*HEX_DIGITS-1:0] = hex_q;
        if (sel_ledr)  rdata[LEDR_BITS-1:0]    = ledr_q;
        if (sel_ledg)  rdata[LEDG_BITS-1:0]    = ledg_q;
        if (sel_kdata) rdata[KEY_BITS-1:0]     = kdata_q;
        if (sel_kctrl) rdata[2:0]              = {kovr_q, 1'b0, krdy_q};
        if (sel_sdata) rdata[SW_BITS-1:0]      = sdata_q;
        if (sel_sctrl) rdata[2:0]              = {sovr_q, 1'b0, srdy_q};
`ifdef MMIO_TIMER_EN
        if (sel_tcnt)  rdata                   = tcnt_q;
        if (sel_tlim)  rdata                   = tlim_q;
        if (sel_tctl)  rdata[2:0]              = {tovr_q, 1'b0, trdy_q};
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < HEX_DIGITS; gi++) begin : g_hex
            logic [6:0] seg;
            always_comb begin
                case (hex_q[4*gi+3:4*gi])
                    4'h0: seg = 7'b1000000;
                    4'h1: seg = 7'b1111001;
                    4'h2: seg = 7'b0100100;
                    4'h3: seg = 7'b0110000;
                    4'h4: seg = 7'b0011001;
                    4'h5: seg = 7'b0010010;
                    4'h6: seg = 7'b0000010;
                    4'h7: seg = 7'b1111000;
                    4'h8: seg = 7'b0000000;
                    4'h9: seg = 7'b0010000;
                    4'hA: seg = 7'b0001000;
                    4'hB: seg = 7'b0000011;
                    4'hC: seg = 7'b1000110;
                    4'hD: seg = 7'b0100001;
                    4'hE: seg = 7'b0000110;
                    default: seg = 7'b0001110;
                endcase
            end
            assign hex[7*gi+6:7*gi] = seg;
        end
    endgenerate

    assign ledr = ledr_q;
    assign ledg = ledg_q;
endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Directed bench for mmio_periph_ctrl: reset, HEX decode, key/switch status, and timer map.
// Timer checks follow MMIO_TIMER_EN; without it the timer addresses must be unmapped.
module tb_mmio_periph_ctrl;
    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_LEDG  = 32'hF000_0008;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_TLIM  = 32'hF000_0024;
    localparam logic [31:0] A_TCTL  = 32'hF000_0120;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [27:0] hex;

    int n_checks = 0;
    int n_errors = 0;

    mmio_periph_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrEn(wrEn), .wdata(wdata),
        .rdata(rdata), .hit(hit), .key(key), .sw(sw), .ledr(ledr), .ledg(ledg), .hex(hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wrEn = 1'b1;
        tick(1);
        wrEn = 1'b0;
        $display("write %h <= %h", a, d);
    endtask

    task automatic rd_clear(input logic [31:0] a);
        addr = a; rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        $display("read  %h (side-effecting)", a);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    logic [6:0]  seg0, seg1, seg2, segA, segF;
    logic [27:0] hex_exp;
    logic        done;

    initial begin
        seg0 = 7'b1000000; seg1 = 7'b1111001; seg2 = 7'b0100100;
        segA = 7'b0001000; segF = 7'b0001110;
        reset = 1'b1; addr = '0; rdEn = 1'b0; wrEn = 1'b0; wdata = '0;
        key = 4'b1111; sw = '0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Reset state
        check("hex_rst", {4'h0, hex}, {4'h0, seg0, seg0, seg0, seg0});
        peek("hex_reg_rst", A_HEX, 32'h0);
        check("hit_hex", {31'h0, hit}, 32'h1);
        peek("kctrl_rst", A_KCTRL, 32'h0);
        peek("unmapped", 32'hF000_0030, 32'h0);
        check("hit_unmap", {31'h0, hit}, 32'h0);

        // HEX / LED writes
        wr(A_HEX, 32'h0000_1A2F);
        hex_exp = {seg1, segA, seg2, segF};
        check("hex_1a2f", {4'h0, hex}, {4'h0, hex_exp});
        check("hex_d0", {25'h0, hex[6:0]}, 32'h0000_000E);
        peek("hex_reg", A_HEX, 32'h0000_1A2F);
        wr(A_LEDR, 32'hFFFF_FEA5);
        check("ledr", {22'h0, ledr}, 32'h0000_02A5);
        wr(A_LEDG, 32'hFFFF_FFAB);
        check("ledg", {24'h0, ledg}, 32'h0000_00AB);
        peek("ledg_reg", A_LEDG, 32'h0000_00AB);

        // Key path: three-edge latency, then read-to-clear
        key = 4'b1110;
        tick(2);
        peek("kdata_early", A_KDATA, 32'h0);
        tick(1);
        peek("kdata_1", A_KDATA, 32'h1);
        peek("kctrl_rdy", A_KCTRL, 32'h1);
        rd_clear(A_KDATA);
        peek("kctrl_clr", A_KCTRL, 32'h0);
        peek("kdata_keep", A_KDATA, 32'h1);

        // Overrun, clear by CTRL write, then same-edge update and read
        key = 4'b1100;
        tick(3);
        peek("kdata_3", A_KDATA, 32'h3);
        key = 4'b1000;
        tick(3);
        peek("kctrl_ovr", A_KCTRL, 32'h5);
        wr(A_KCTRL, 32'h0000_0005);
        peek("kctrl_b2set", A_KCTRL, 32'h5);
        wr(A_KCTRL, 32'h0);
        peek("kctrl_ovclr", A_KCTRL, 32'h1);
        key = 4'b0000;
        tick(2);
        rd_clear(A_KDATA);
        peek("kctrl_same", A_KCTRL, 32'h1);
        peek("kdata_f", A_KDATA, 32'hF);
        wr(A_KDATA, 32'h0);
        peek("kdata_nowr", A_KDATA, 32'hF);

        // Switch debounce: short glitch is rejected
        sw = 10'h155;
        tick(2);
        sw = 10'h000;
        tick(10);
        peek("sdata_glitch", A_SDATA, 32'h0);
        peek("sctrl_glitch", A_SCTRL, 32'h0);
        sw = 10'h2AA;
        tick(3);
        peek("sdata_early", A_SDATA, 32'h0);
        addr = A_SDATA;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick(1);
            if (rdata == 32'h2AA) done = 1'b1;
        end
        check("sdata_wait", {31'h0, done}, 32'h1);
        peek("sdata_2aa", A_SDATA, 32'h2AA);
        peek("sctrl_rdy", A_SCTRL, 32'h1);
        rd_clear(A_SDATA);
        peek("sctrl_clr", A_SCTRL, 32'h0);

`ifdef MMIO_TIMER_EN
        wr(A_TLIM, 32'h3);
        wr(A_TCNT, 32'h0);
        peek("tcnt_0", A_TCNT, 32'h0);
        tick(2);
        peek("tcnt_1", A_TCNT, 32'h1);
        tick(2);
        peek("tcnt_2", A_TCNT, 32'h2);
        peek("tctl_pre", A_TCTL, 32'h0);
        tick(2);
        peek("tcnt_wrap", A_TCNT, 32'h0);
        peek("tctl_rdy", A_TCTL, 32'h1);
        peek("tlim", A_TLIM, 32'h3);
        rd_clear(A_TCNT);
        peek("tctl_clr", A_TCTL, 32'h0);
`else
        wr(A_TCTL, 32'hFFFF_FFFF);
        peek("tctl_unmap", A_TCTL, 32'h0);
        check("tctl_hit", {31'h0, hit}, 32'h0);
        peek("tcnt_unmap", A_TCNT, 32'h0);
        check("tcnt_hit", {31'h0, hit}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
